// File: rtl/l1i_miss_handler.sv
// l1i_miss_handler: merges per-thread L1I misses, issues one L2 read per line, fills the L1I and wakes waiters.
// Optional perf outputs (merge pulse, fill counter) are built only when L1I_MISS_PERF_EN is defined.
module l1i_miss_handler #(
  parameter int THREADS = 4,
  parameter int WAYS = 4,
  parameter int SET_BITS = 6,
  parameter int LINE_BITS = 512,
  localparam int TID_BITS = $clog2(THREADS),
  localparam int WAY_BITS = $clog2(WAYS),
  localparam int TAG_BITS = 32 - 6 - SET_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ifd_cache_miss,
  input  logic [31:0]          ifd_cache_miss_addr,
  input  logic [TID_BITS-1:0]  ifd_cache_miss_thread_idx,
  output logic                 l2i_request_valid,
  output logic [31:0]          l2i_request_addr,
  input  logic                 l2i_request_ready,
  input  logic                 l2_response_valid,
  input  logic [31:0]          l2_response_addr,
  input  logic [LINE_BITS-1:0] l2_response_data,
  output logic                 l2i_idata_update_en,
  output logic [WAY_BITS-1:0]  l2i_idata_update_way,
  output logic [SET_BITS-1:0]  l2i_idata_update_set,
  output logic [LINE_BITS-1:0] l2i_idata_update_data,
  output logic [WAYS-1:0]      l2i_itag_update_en_oh,
  output logic [SET_BITS-1:0]  l2i_itag_update_set,
  output logic [TAG_BITS-1:0]  l2i_itag_update_tag,
  output logic [THREADS-1:0]   l2i_wake_bitmap,
  output logic                 perf_miss_merged,
  output logic [31:0]          perf_fill_count
);
  typedef enum logic [1:0] {EMPTY, WAIT_ISSUE, WAIT_RESPONSE} entry_state_t;
  entry_state_t       state_q [THREADS];
  entry_state_t       state_d [THREADS];
  logic [31:0]        addr_q [THREADS];
  logic [31:0]        addr_d [THREADS];
  logic [THREADS-1:0] waiters_q [THREADS];
  logic [THREADS-1:0] waiters_d [THREADS];
  logic [THREADS-1:0] empty_vec, issue_vec, merge_vec, resp_vec, thread_bit;
  logic [TID_BITS-1:0] alloc_idx, issue_idx, resp_idx;
  logic merge_hit, alloc, handshake, resp_hit, stale;
  logic [WAY_BITS-1:0] rr;

  function automatic logic [TID_BITS-1:0] lowest(input logic [THREADS-1:0] v);
    lowest = '0;
    for (int i = THREADS - 1; i >= 0; i--) if (v[i]) lowest = TID_BITS'(i);
  endfunction

  always_comb begin
    empty_vec = '0;
    issue_vec = '0;
    merge_vec = '0;
    resp_vec = '0;
    for (int i = 0; i < THREADS; i++) begin
      empty_vec[i] = state_q[i] == EMPTY;
      issue_vec[i] = state_q[i] == WAIT_ISSUE;
      merge_vec[i] = ifd_cache_miss && state_q[i] != EMPTY && addr_q[i] == ifd_cache_miss_addr;
      resp_vec[i] = l2_response_valid && state_q[i] == WAIT_RESPONSE && addr_q[i] == l2_response_addr;
    end
  end

  assign thread_bit = THREADS'(1) << ifd_cache_miss_thread_idx;
  assign merge_hit = |merge_vec;
  assign alloc = ifd_cache_miss && !merge_hit && |empty_vec;
  assign handshake = l2i_request_valid && l2i_request_ready;
  assign resp_hit = |resp_vec;
  assign alloc_idx = lowest(empty_vec);
  assign issue_idx = lowest(issue_vec);
  assign resp_idx = lowest(resp_vec);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < THREADS; i++) begin
        state_q[i] <= EMPTY;
        addr_q[i] <= '0;
        waiters_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      waiters_q <= waiters_d;
    end
  end

  // An entry freed by a response this cycle still reads EMPTY-false here, so it is not reallocated until next cycle.
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    waiters_d = waiters_q;
    for (int i = 0; i < THREADS; i++) begin
      if (merge_vec[i]) waiters_d[i] = waiters_q[i] | thread_bit;
      if (alloc && alloc_idx == TID_BITS'(i)) begin
        state_d[i] = WAIT_ISSUE;
        addr_d[i] = ifd_cache_miss_addr;
        waiters_d[i] = thread_bit;
      end
      if (handshake && issue_idx == TID_BITS'(i)) state_d[i] = WAIT_RESPONSE;
      if (resp_hit && resp_idx == TID_BITS'(i)) state_d[i] = EMPTY;
    end
  end

  always_comb begin
    l2i_request_valid = |issue_vec;
    l2i_request_addr = l2i_request_valid ? addr_q[issue_idx] : '0;
    l2i_itag_update_en_oh = WAYS'(l2i_idata_update_en) << l2i_idata_update_way;
    l2i_itag_update_set = l2i_idata_update_set;
  end

  // Waiters come from the next-state view so a same-cycle merge into the filling line is woken too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l2i_idata_update_en <= 1'b0;
      l2i_idata_update_way <= '0;
      l2i_idata_update_set <= '0;
      l2i_idata_update_data <= '0;
      l2i_itag_update_tag <= '0;
      l2i_wake_bitmap <= '0;
      rr <= '0;
    end else begin
      l2i_idata_update_en <= resp_hit;
      l2i_idata_update_way <= resp_hit ? rr : '0;
      l2i_idata_update_set <= resp_hit ? l2_response_addr[6 +: SET_BITS] : '0;
      l2i_idata_update_data <= resp_hit ? l2_response_data : '0;
      l2i_itag_update_tag <= resp_hit ? l2_response_addr[31 -: TAG_BITS] : '0;
      l2i_wake_bitmap <= resp_hit ? waiters_d[resp_idx] : '0;
      if (resp_hit) rr <= (rr == WAY_BITS'(WAYS - 1)) ? '0 : rr + WAY_BITS'(1);
    end
  end

  // Responses to lines dropped by a reset may still arrive; excuse unmatched ones until a response matches again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stale <= 1'b1;
    else if (resp_hit) stale <= 1'b0;
  end

  assert property (@(posedge clk) disable iff (reset) ifd_cache_miss && !merge_hit |-> |empty_vec);
  assert property (@(posedge clk) disable iff (reset) l2_response_valid && !stale |-> resp_hit);

`ifdef L1I_MISS_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_miss_merged <= 1'b0;
      perf_fill_count <= '0;
    end else begin
      perf_miss_merged <= merge_hit;
      perf_fill_count <= perf_fill_count + 32'(l2i_idata_update_en);
    end
  end
`else
  assign perf_miss_merged = 1'b0;
  assign perf_fill_count = '0;
`endif
endmodule

// File: tb/tb_l1i_miss_handler.sv
// tb_l1i_miss_handler: directed and randomized checks of l1i_miss_handler against a line-level reference model.
module tb_l1i_miss_handler;
  localparam int T = 4;
  localparam int W = 4;
`ifdef L1I_MISS_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ifd_cache_miss = 1'b0;
  logic [31:0] ifd_cache_miss_addr = '0;
  logic [1:0] ifd_cache_miss_thread_idx = '0;
  logic l2i_request_valid;
  logic [31:0] l2i_request_addr;
  logic l2i_request_ready = 1'b0;
  logic l2_response_valid = 1'b0;
  logic [31:0] l2_response_addr = '0;
  logic [511:0] l2_response_data = '0;
  logic l2i_idata_update_en;
  logic [1:0] l2i_idata_update_way;
  logic [5:0] l2i_idata_update_set;
  logic [511:0] l2i_idata_update_data;
  logic [3:0] l2i_itag_update_en_oh;
  logic [5:0] l2i_itag_update_set;
  logic [19:0] l2i_itag_update_tag;
  logic [3:0] l2i_wake_bitmap;
  logic perf_miss_merged;
  logic [31:0] perf_fill_count;

  int checks = 0;
  int failures = 0;
  int st [T];
  logic [31:0] ma [T];
  logic [3:0] mw [T];
  bit busy [T];
  int rr_m = 0;
  int fills_prev = 0;
  int n_hs = 0;
  int merged_seen = 0;
  logic [31:0] issued [$];

  always #5 clk = ~clk;

  l1i_miss_handler dut (
    .clk(clk), .reset(reset),
    .ifd_cache_miss(ifd_cache_miss), .ifd_cache_miss_addr(ifd_cache_miss_addr),
    .ifd_cache_miss_thread_idx(ifd_cache_miss_thread_idx),
    .l2i_request_valid(l2i_request_valid), .l2i_request_addr(l2i_request_addr),
    .l2i_request_ready(l2i_request_ready),
    .l2_response_valid(l2_response_valid), .l2_response_addr(l2_response_addr),
    .l2_response_data(l2_response_data),
    .l2i_idata_update_en(l2i_idata_update_en), .l2i_idata_update_way(l2i_idata_update_way),
    .l2i_idata_update_set(l2i_idata_update_set), .l2i_idata_update_data(l2i_idata_update_data),
    .l2i_itag_update_en_oh(l2i_itag_update_en_oh), .l2i_itag_update_set(l2i_itag_update_set),
    .l2i_itag_update_tag(l2i_itag_update_tag), .l2i_wake_bitmap(l2i_wake_bitmap),
    .perf_miss_merged(perf_miss_merged), .perf_fill_count(perf_fill_count)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < T; i++) begin
      st[i] = 0;
      ma[i] = '0;
      mw[i] = '0;
      busy[i] = 1'b0;
    end
    rr_m = 0;
    fills_prev = 0;
  endtask

  // One clock: drive inputs, check request outputs, predict the line-level outcome, check fill outputs.
  task automatic step(input bit miss, input logic [31:0] maddr, input int tid, input bit rdy, input bit rv, input logic [31:0] raddr);
    logic [511:0] d;
    logic [3:0] tbit, wk;
    int m, a, k, iss;
    bit fe;
    d = rand_line();
    m = -1; a = -1; k = -1; iss = -1;
    ifd_cache_miss = miss;
    ifd_cache_miss_addr = maddr;
    ifd_cache_miss_thread_idx = 2'(tid);
    l2i_request_ready = rdy;
    l2_response_valid = rv;
    l2_response_addr = raddr;
    l2_response_data = d;
    for (int i = T - 1; i >= 0; i--) begin
      if (st[i] != 0 && ma[i] == maddr) m = i;
      if (st[i] == 0) a = i;
      if (st[i] == 1) iss = i;
      if (st[i] == 2 && ma[i] == raddr) k = i;
    end
    #1;
    chk("req_valid", l2i_request_valid, iss >= 0);
    if (iss >= 0) chk("req_addr", l2i_request_addr, ma[iss]);
    if (l2i_request_valid && rdy) begin
      n_hs++;
      issued.push_back(l2i_request_addr);
    end
    tbit = 4'b1 << tid;
    m = miss ? m : -1;
    fe = rv && k >= 0;
    wk = fe ? (mw[k] | ((m == k) ? tbit : 4'b0)) : 4'b0;
    if (m >= 0) mw[m] |= tbit;
    else if (miss && a >= 0) begin
      st[a] = 1;
      ma[a] = maddr;
      mw[a] = tbit;
    end
    if (rdy && iss >= 0) st[iss] = 2;
    if (fe) st[k] = 0;
    if (miss) busy[tid] = 1'b1;
    @(posedge clk);
    #1;
    chk("fill_en", l2i_idata_update_en, fe);
    chk("fill_way", l2i_idata_update_way, fe ? rr_m : 0);
    chk("tag_oh", l2i_itag_update_en_oh, fe ? (4'b1 << rr_m) : 4'b0);
    chk("data_set", l2i_idata_update_set, fe ? raddr[11:6] : 6'd0);
    chk("tag_set", l2i_itag_update_set, fe ? raddr[11:6] : 6'd0);
    chk("tag", l2i_itag_update_tag, fe ? raddr[31:12] : 20'd0);
    chk("data", l2i_idata_update_data, fe ? d : 512'd0);
    chk("wake", l2i_wake_bitmap, wk);
    chk("perf_merged", perf_miss_merged, PERF && m >= 0);
    chk("perf_count", perf_fill_count, PERF ? fills_prev : 0);
    if (perf_miss_merged) merged_seen++;
    if (fe) begin
      fills_prev++;
      rr_m = (rr_m + 1) % W;
      for (int t = 0; t < T; t++) if (wk[t]) busy[t] = 1'b0;
    end
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 32'h0, 0, rdy, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifd_cache_miss = 1'b0;
    l2_response_valid = 1'b0;
    l2i_request_ready = 1'b0;
    #1;
    chk("rst_req_valid", l2i_request_valid, 0);
    chk("rst_req_addr", l2i_request_addr, 0);
    chk("rst_fill_en", l2i_idata_update_en, 0);
    chk("rst_tag_oh", l2i_itag_update_en_oh, 0);
    chk("rst_wake", l2i_wake_bitmap, 0);
    chk("rst_data", l2i_idata_update_data, 0);
    chk("rst_perf_count", perf_fill_count, 0);
    chk("rst_perf_merged", perf_miss_merged, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    int hs0, mg0, tid;
    bit mv, rv;
    logic [31:0] maddr, ra;
    int free [$];
    int wr [$];
    model_clear();
    do_reset();
    // single miss
    issued.delete();
    step(1'b1, 32'h00001040, 1, 1'b1, 1'b0, 32'h0);
    idle(1'b1);
    chk("t1_issue_count", issued.size(), 1);
    chk("t1_issue_addr", issued[0], 32'h00001040);
    step(1'b0, 32'h0, 0, 1'b1, 1'b1, 32'h00001040);
    chk("t1_en", l2i_idata_update_en, 1);
    chk("t1_way", l2i_idata_update_way, 0);
    chk("t1_set", l2i_idata_update_set, 6'h01);
    chk("t1_tag", l2i_itag_update_tag, 20'h00001);
    chk("t1_wake", l2i_wake_bitmap, 4'b0010);
    // merge of three threads onto one line
    hs0 = n_hs;
    mg0 = merged_seen;
    step(1'b1, 32'h00002000, 0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h00002000, 2, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h00002000, 3, 1'b0, 1'b0, 32'h0);
    idle(1'b1);
    idle(1'b1);
    chk("t2_one_request", n_hs - hs0, 1);
    step(1'b0, 32'h0, 0, 1'b1, 1'b1, 32'h00002000);
    chk("t2_wake", l2i_wake_bitmap, 4'b1101);
    chk("t2_merge_pulses", merged_seen - mg0, PERF ? 2 : 0);
    // back-pressure then in-order issue
    do_reset();
    step(1'b1, 32'h00004000, 0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h00005040, 1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h00006080, 2, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      idle(1'b0);
      chk("bp_valid", l2i_request_valid, 1);
      chk("bp_addr", l2i_request_addr, 32'h00004000);
    end
    issued.delete();
    repeat (4) idle(1'b1);
    chk("bp_issue_count", issued.size(), 3);
    chk("bp_issue0", issued[0], 32'h00004000);
    chk("bp_issue1", issued[1], 32'h00005040);
    chk("bp_issue2", issued[2], 32'h00006080);
    // responses in reverse issue order
    step(1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h00006080);
    chk("ooo0_way", l2i_idata_update_way, 0);
    chk("ooo0_set", l2i_idata_update_set, 6'h02);
    chk("ooo0_tag", l2i_itag_update_tag, 20'h00006);
    chk("ooo0_wake", l2i_wake_bitmap, 4'b0100);
    idle(1'b0);
    step(1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h00005040);
    chk("ooo1_way", l2i_idata_update_way, 1);
    chk("ooo1_set", l2i_idata_update_set, 6'h01);
    chk("ooo1_wake", l2i_wake_bitmap, 4'b0010);
    step(1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h00004000);
    chk("ooo2_way", l2i_idata_update_way, 2);
    chk("ooo2_tag", l2i_itag_update_tag, 20'h00004);
    chk("ooo2_wake", l2i_wake_bitmap, 4'b0001);
    // merge in the same cycle as the response
    step(1'b1, 32'h00003000, 0, 1'b1, 1'b0, 32'h0);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 32'h00003000, 3, 1'b1, 1'b1, 32'h00003000);
    chk("sc_wake", l2i_wake_bitmap, 4'b1001);
    hs0 = n_hs;
    idle(1'b1);
    idle(1'b1);
    chk("sc_no_request", n_hs - hs0, 0);
    // reset with two lines outstanding at L2
    step(1'b1, 32'h00007000, 0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h00008040, 1, 1'b1, 1'b0, 32'h0);
    idle(1'b1);
    chk("mid_both_issued", st[0] == 2 && st[1] == 2, 1);
    do_reset();
    step(1'b0, 32'h0, 0, 1'b1, 1'b1, 32'h00007000);
    chk("mid_no_fill", l2i_idata_update_en, 0);
    chk("mid_no_wake", l2i_wake_bitmap, 0);
    idle(1'b1);
    chk("mid_fill_count", perf_fill_count, 0);
    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      mv = 1'b0;
      tid = 0;
      maddr = '0;
      rv = 1'b0;
      ra = '0;
      free.delete();
      wr.delete();
      for (int t = 0; t < T; t++) if (!busy[t]) free.push_back(t);
      if ($urandom_range(0, 9) < 4 && free.size() > 0) begin
        mv = 1'b1;
        tid = free[$urandom_range(0, free.size() - 1)];
        maddr = 32'($urandom_range(1, 6)) * 32'h00011040;
      end
      for (int i = 0; i < T; i++) if (st[i] == 2) wr.push_back(i);
      if (wr.size() > 0 && $urandom_range(0, 1) == 1) begin
        rv = 1'b1;
        ra = ma[wr[$urandom_range(0, wr.size() - 1)]];
      end
      step(mv, maddr, tid, $urandom_range(0, 9) < 6, rv, ra);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/l1i_miss_handler.md
Name: l1i_miss_handler

Overview:
- Miss-handling end of the L1 instruction cache interface.
- Accepts miss requests from the instruction fetch data stage and merges duplicate misses from several threads to one line.
- Issues one L2 read per unique line and, on the L2 response, drives the L1I tag and data fill ports back into the fetch pipeline.
- On each fill, wakes every thread waiting on that line.

Parameters:
- THREADS, 4, hardware threads per core; also the number of miss entries (each thread has at most one outstanding miss).
- WAYS, 4, L1I associativity.
- SET_BITS, 6, L1I set index width.
- LINE_BITS, 512, cache line width (64-byte line, 6 offset bits).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ifd_cache_miss  in  1  miss request valid (single cycle; cannot be back-pressured)
- ifd_cache_miss_addr  in  32  line-aligned miss address
- ifd_cache_miss_thread_idx  in  $clog2(THREADS)  requesting thread
- l2i_request_valid  out  1  L2 read request valid
- l2i_request_addr  out  32  L2 read line address
- l2i_request_ready  in  1  L2 accepts request
- l2_response_valid  in  1  L2 fill data valid (always accepted)
- l2_response_addr  in  32  fill line address
- l2_response_data  in  LINE_BITS  fill data
- l2i_idata_update_en  out  1  data array write
- l2i_idata_update_way  out  $clog2(WAYS)  victim way
- l2i_idata_update_set  out  SET_BITS  set index
- l2i_idata_update_data  out  LINE_BITS  line data
- l2i_itag_update_en_oh  out  WAYS  one-hot tag write
- l2i_itag_update_set  out  SET_BITS  set index
- l2i_itag_update_tag  out  32-6-SET_BITS  tag
- l2i_wake_bitmap  out  THREADS  threads to resume (single-cycle pulse)
- perf_miss_merged  out  1  merge event (see Optional Feature)
- perf_fill_count  out  32  fills completed (see Optional Feature)

Behaviour:
- Entry state machine: THREADS entries, each EMPTY -> WAIT_ISSUE -> WAIT_RESPONSE -> EMPTY. Each entry holds addr and a waiters bitmap.
- Miss intake, merge case: if the address equals the addr of any non-EMPTY entry, OR the thread bit into that entry's waiters. No allocation; perf_miss_merged pulses.
- Miss intake, allocate case: otherwise, allocate the lowest-index EMPTY entry into WAIT_ISSUE with waiters = that thread's bit.
- Miss intake, overflow: no EMPTY entry is an assertion failure. It cannot occur legally.
- Issue: l2i_request_valid=1 whenever any entry is in WAIT_ISSUE.
  - l2i_request_addr = addr of the lowest-index WAIT_ISSUE entry.
  - Valid and addr stay stable until ready; on valid&&ready the entry moves to WAIT_RESPONSE.
  - A newly allocated entry may issue the cycle after allocation, not the same cycle.
- Response capture, cycle N: l2_response_valid matches a WAIT_RESPONSE entry's addr. Capture data, set, tag, victim way, and the entry's waiters as of the end of cycle N, including any merge in cycle N. The entry goes EMPTY at the end of N.
  - Response with no matching entry: ignored; assertion failure.
- Fill outputs, cycle N+1 (all registered, latency 1):
  - l2i_idata_update_en=1 and l2i_itag_update_en_oh=1<<victim, with set/tag/data from l2_response_addr/data.
  - l2i_wake_bitmap = captured waiters.
  - All are zero in every other cycle.
- Victim selection: a global round-robin counter of $clog2(WAYS) bits supplies the victim way at capture. It increments (wrapping WAYS-1 -> 0) once per fill.
- Miss in cycle N+1 for the filling line: the fetch stage suppresses this via its near-miss check. If one arrives anyway, the block allocates a new entry; the refetch is harmless.
- Simultaneous events in one cycle are all legal: miss intake, request handshake and response capture.
  - If the response frees entry k in the same cycle a miss needs allocation, entry k is not reused until the next cycle.
- Reset: all entries EMPTY, round-robin counter 0, perf_fill_count 0.
  - All outputs 0, including l2i_request_valid, the fill enables and l2i_wake_bitmap.
  - Reset mid-transaction drops all pending entries. Later responses for them are ignored.

Optional Feature:
- Macro L1I_MISS_PERF_EN.
- Defined: perf_miss_merged pulses one cycle for each merge at intake. perf_fill_count increments by 1 on each cycle with l2i_idata_update_en=1, wrapping at 2^32.
- Not defined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Single miss: thread 1 misses on 0x00001040, ready=1 -> request 0x00001040 the next cycle.
  - Response 0x00001040 at cycle N -> at N+1: idata_update_en=1, way 0, set 0x01, tag 0x00001, wake_bitmap 0b0010.
- Merge: threads 0, 2, 3 miss on 0x00002000 in consecutive cycles -> exactly one request.
  - Fill -> wake_bitmap 0b1101; perf_miss_merged pulses twice (macro defined).
- Back-pressure: 3 distinct misses with ready=0 for 10 cycles -> request_valid stays 1 with the lowest-entry addr stable.
  - Ready=1 -> addresses issue in entry order, one per cycle.
- Out-of-order responses: responses return in reverse issue order -> each fill carries the correct set/tag/waiters. Victim ways are 0, 1, 2 in fill order.
- Same-cycle merge and response: thread 3 misses on 0x00003000 in the same cycle the response for 0x00003000 arrives (waiters 0b0001) -> wake_bitmap 0b1001 and no new request issued.
- Reset mid-flight: reset while 2 entries are in WAIT_RESPONSE -> all outputs 0.
  - A later response for one of them -> no fill and no wake; perf_fill_count stays 0.
